// File: rtl/ov7670_stream_tx_pkg.sv
// Shared geometry defaults, pipeline latency and timing-generator state encoding
// for the OV7670-format video transmitter.
package ov7670_stream_tx_pkg;

  // QQVGA RGB565: 160 px * 2 bytes per line
  localparam int unsigned DefHActive    = 320;
  localparam int unsigned DefHBlank     = 16;
  localparam int unsigned DefVActive    = 120;
  localparam int unsigned DefVsyncLines = 3;
  localparam int unsigned DefVBack      = 2;
  localparam int unsigned DefVFront     = 2;
  localparam logic [15:0] DefBaseAddr   = 16'h0000;

  // Address-to-byte latency: RAM read register plus the d output register
  localparam int unsigned RdLat = 2;

  // StDrain covers the RdLat cycles needed to flush the output pipeline
  // before the frame is reported done.
  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVback,
    StActive,
    StVfront,
    StDrain
  } tx_state_e;

endpackage

// File: rtl/ov7670_timing_gen.sv
// Line/frame timing generator: phase FSM plus horizontal and vertical counters.
// Outputs are on the address timeline (RdLat cycles ahead of the pins).
module ov7670_timing_gen
  import ov7670_stream_tx_pkg::*;
#(
  parameter int unsigned HActive    = DefHActive,
  parameter int unsigned HBlank     = DefHBlank,
  parameter int unsigned VActive    = DefVActive,
  parameter int unsigned VsyncLines = DefVsyncLines,
  parameter int unsigned VBack      = DefVBack,
  parameter int unsigned VFront     = DefVFront
) (
  input  logic pclk_24_i,
  input  logic reset_n_i,
  input  logic start_i,
  output logic busy_o,
  output logic vsync_pre_o,
  output logic href_pre_o,
  output logic rd_en_o,
  output logic frame_end_o
);

  localparam int unsigned LineLen = HActive + HBlank;
  localparam int unsigned HW      = $clog2(LineLen + RdLat + 1);
  localparam int unsigned VW      = $clog2(VActive + VsyncLines + VBack + VFront + 1);

  tx_state_e       state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;
  int unsigned     phase_lines;
  tx_state_e       phase_next;

  // Line count of the current phase and the phase that follows it (empty phases skipped)
  always_comb begin
    phase_lines = 1;
    phase_next  = StIdle;
    case (state_q)
      StVsync: begin
        phase_lines = VsyncLines;
        phase_next  = (VBack != 0) ? StVback : StActive;
      end
      StVback: begin
        phase_lines = VBack;
        phase_next  = StActive;
      end
      StActive: begin
        phase_lines = VActive;
        phase_next  = (VFront != 0) ? StVfront : StDrain;
      end
      StVfront: begin
        phase_lines = VFront;
        phase_next  = StDrain;
      end
      default: begin
        phase_lines = 1;
        phase_next  = StIdle;
      end
    endcase
  end

  // Next-state and counter update
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    frame_end_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StVsync;
          hcnt_d  = '0;
          vcnt_d  = '0;
        end
      end
      StDrain: begin
        if (hcnt_q == HW'(RdLat - 1)) begin
          state_d     = StIdle;
          hcnt_d      = '0;
          frame_end_o = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        if (hcnt_q == HW'(LineLen - 1)) begin
          hcnt_d = '0;
          if (vcnt_q == VW'(phase_lines - 1)) begin
            vcnt_d  = '0;
            state_d = phase_next;
          end else begin
            vcnt_d = vcnt_q + 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge pclk_24_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign vsync_pre_o = (state_q == StVsync);
  assign href_pre_o  = (state_q == StActive) && (hcnt_q < HW'(HActive));
  assign rd_en_o     = href_pre_o;

endmodule

// File: rtl/ov7670_stream_tx.sv
// OV7670-format parallel video transmitter: reads a framebuffer through a
// synchronous-read port and emits vsync/href/d with RdLat-aligned timing.
module ov7670_stream_tx
  import ov7670_stream_tx_pkg::*;
#(
  parameter int unsigned HActive    = DefHActive,
  parameter int unsigned HBlank     = DefHBlank,
  parameter int unsigned VActive    = DefVActive,
  parameter int unsigned VsyncLines = DefVsyncLines,
  parameter int unsigned VBack      = DefVBack,
  parameter int unsigned VFront     = DefVFront,
  parameter logic [15:0] BaseAddr   = DefBaseAddr
) (
  input  logic        pclk_24_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [7:0]  din_i,
  output logic [15:0] addr_o,
  output logic        vsync_o,
  output logic        href_o,
  output logic [7:0]  d_o,
  output logic        busy_o,
  output logic        done_o
);

  logic              vsync_pre, href_pre, rd_en, frame_end;
  logic [15:0]       addr_q, addr_d;
  logic [RdLat-1:0]  vs_q, hr_q;
  logic [7:0]        d_q, d_d;

  ov7670_timing_gen #(
    .HActive    (HActive),
    .HBlank     (HBlank),
    .VActive    (VActive),
    .VsyncLines (VsyncLines),
    .VBack      (VBack),
    .VFront     (VFront)
  ) u_timing_gen (
    .pclk_24_i   (pclk_24_i),
    .reset_n_i   (reset_n_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .vsync_pre_o (vsync_pre),
    .href_pre_o  (href_pre),
    .rd_en_o     (rd_en),
    .frame_end_o (frame_end)
  );

  // Address advances after each read cycle; rewinds to the frame base when the frame ends
  always_comb begin
    addr_d = addr_q;
    if (frame_end) begin
      addr_d = BaseAddr;
    end else if (rd_en) begin
      addr_d = addr_q + 16'd1;
    end
  end

  // Capture RAM data only while the delayed href says it is a valid byte
  always_comb begin
    d_d = '0;
    if (hr_q[RdLat-2]) begin
      d_d = din_i;
    end
  end

  // Address, sync delay line, data and done registers
  always_ff @(posedge pclk_24_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_q <= BaseAddr;
      vs_q   <= '0;
      hr_q   <= '0;
      d_q    <= '0;
      done_o <= 1'b0;
    end else begin
      addr_q <= addr_d;
      vs_q   <= {vs_q[RdLat-2:0], vsync_pre};
      hr_q   <= {hr_q[RdLat-2:0], href_pre};
      d_q    <= d_d;
      done_o <= frame_end;
    end
  end

  assign addr_o  = addr_q;
  assign vsync_o = vs_q[RdLat-1];
  assign href_o  = hr_q[RdLat-1];
  assign d_o     = d_q;

endmodule

// File: tb/tb_ov7670_stream_tx.sv
// Bench for ov7670_stream_tx: tiny geometry, framebuffer model with a
// synchronous read port, and a frame-level reference built from line arithmetic.
module tb_ov7670_stream_tx;

  localparam int HA = 4, HB = 2, VA = 3, VS = 1, VB = 1, VF = 1;
  localparam int LL = HA + HB;
  localparam int NL = VS + VB + VA + VF;
  localparam int F  = NL * LL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b;
  logic [7:0]  din_a, din_b, d_a, d_b;
  logic [15:0] addr_a, addr_b;
  logic        vs_a, vs_b, hr_a, hr_b, busy_a, busy_b, done_a, done_b;

  ov7670_stream_tx #(
    .HActive(HA), .HBlank(HB), .VActive(VA), .VsyncLines(VS), .VBack(VB), .VFront(VF),
    .BaseAddr(16'h0000)
  ) dut_a (
    .pclk_24_i(clk), .reset_n_i(rst_n), .start_i(start_a), .din_i(din_a),
    .addr_o(addr_a), .vsync_o(vs_a), .href_o(hr_a), .d_o(d_a), .busy_o(busy_a),
    .done_o(done_a)
  );

  ov7670_stream_tx #(
    .HActive(HA), .HBlank(HB), .VActive(VA), .VsyncLines(VS), .VBack(VB), .VFront(VF),
    .BaseAddr(16'hFFFE)
  ) dut_b (
    .pclk_24_i(clk), .reset_n_i(rst_n), .start_i(start_b), .din_i(din_b),
    .addr_o(addr_b), .vsync_o(vs_b), .href_o(hr_b), .d_o(d_b), .busy_o(busy_b),
    .done_o(done_b)
  );

  logic [7:0] mem [65536];
  always @(posedge clk) begin
    din_a <= mem[addr_a];
    din_b <= mem[addr_b];
  end

  bit          sel;
  logic [15:0] o_addr;
  logic        o_vs, o_hr, o_busy, o_done;
  logic [7:0]  o_d;
  always_comb begin
    o_addr = sel ? addr_b : addr_a;
    o_vs   = sel ? vs_b   : vs_a;
    o_hr   = sel ? hr_b   : hr_a;
    o_d    = sel ? d_b    : d_a;
    o_busy = sel ? busy_b : busy_a;
    o_done = sel ? done_b : done_a;
  end

  int checks = 0;
  int errors = 0;

  // Expected pin values for each output cycle of one frame
  logic        m_vs   [F];
  logic        m_hr   [F];
  logic [7:0]  m_d    [F];
  logic [15:0] m_addr [F];
  logic [15:0] m_base;

  task automatic build(input logic [15:0] base);
    m_base = base;
    for (int line = 0; line < NL; line++) begin
      for (int h = 0; h < LL; h++) begin
        int p = line * LL + h;
        int a = line - VS - VB;
        m_vs[p]   = (line < VS);
        m_hr[p]   = (a >= 0) && (a < VA) && (h < HA);
        m_addr[p] = 16'(int'(base) + a * HA + h);
        m_d[p]    = m_hr[p] ? mem[m_addr[p]] : 8'h00;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Caller sits just after a negedge with the DUT idle. p indexes negedges after start edge.
  task automatic run_frame(input bit hold, input bit extra);
    set_start(1'b1);
    @(posedge clk);
    for (int p = 0; p <= F + 2; p++) begin
      @(negedge clk);
      if (!hold && (p == 0 || (extra && (p == 11 || p == F + 2)))) set_start(1'b0);
      if (extra && (p == 10 || p == F + 1)) set_start(1'b1);
      chk((p < F + 2) ? "busy" : "busy_end", {31'd0, o_busy}, {31'd0, p < F + 2});
      chk("done", {31'd0, o_done}, {31'd0, p == F + 2});
      if (p < F && m_hr[p]) chk("addr", {16'd0, o_addr}, {16'd0, m_addr[p]});
      if (p >= 2 && p < F + 2) begin
        chk("vsync", {31'd0, o_vs}, {31'd0, m_vs[p-2]});
        chk("href", {31'd0, o_hr}, {31'd0, m_hr[p-2]});
        chk("d", {24'd0, o_d}, {24'd0, m_d[p-2]});
      end else begin
        chk("vsync_idle", {31'd0, o_vs}, 32'd0);
        chk("href_idle", {31'd0, o_hr}, 32'd0);
        chk("d_idle", {24'd0, o_d}, 32'd0);
      end
      if (p == F + 2) chk("addr_rewind", {16'd0, o_addr}, {16'd0, m_base});
    end
  endtask

  initial begin
    int rp;
    sel     = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    rst_n   = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i + 'h10);

    repeat (3) @(negedge clk);
    chk("rst_addr_a", {16'd0, addr_a}, 32'h0000);
    chk("rst_addr_b", {16'd0, addr_b}, 32'hFFFE);
    chk("rst_outs", {26'd0, vs_a, hr_a, busy_a, done_a, vs_b, hr_b}, 32'd0);
    chk("rst_d", {16'd0, d_a, d_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame
    build(16'h0000);
    run_frame(1'b0, 1'b0);
    repeat ($urandom_range(1, 5)) @(negedge clk);
    chk("idle_busy", {31'd0, o_busy}, 32'd0);

    // start while busy and on the done edge is ignored
    run_frame(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_restart_busy", {31'd0, o_busy}, 32'd0);
      chk("no_restart_done", {31'd0, o_done}, 32'd0);
    end

    // start held: back-to-back frames with one idle cycle
    for (int f = 0; f < 3; f++) run_frame(1'b1, 1'b0);
    set_start(1'b0);
    @(negedge clk);
    chk("hold_release_busy", {31'd0, o_busy}, 32'd0);

    // Random framebuffer contents
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    build(16'h0000);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    run_frame(1'b0, 1'b0);

    // Asynchronous reset during the second active line
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 'h10);
    build(16'h0000);
    rp = $urandom_range(20, 25);
    set_start(1'b1);
    @(posedge clk);
    for (int p = 0; p <= rp; p++) begin
      @(negedge clk);
      if (p == 0) set_start(1'b0);
    end
    chk("pre_rst_d", {24'd0, o_d}, {24'd0, m_d[rp-2]});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {28'd0, o_vs, o_hr, o_busy, o_done}, 32'd0);
    chk("async_rst_d", {24'd0, o_d}, 32'd0);
    chk("async_rst_addr", {16'd0, o_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(1'b0, 1'b0);

    // Address wrap from 16'hFFFE
    sel = 1'b1;
    build(16'hFFFE);
    run_frame(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov7670_stream_tx.md
Name: ov7670_stream_tx

Overview:
Transmit-side counterpart of the OV7670 capture path. Reads a framebuffer through a synchronous-read port and drives OV7670-format parallel video timing (vsync, href, 8-bit d), one byte per pclk_24 cycle. Serves as an in-fabric sensor emulator: it loops frames into ov7670_capture for self-test and can replay stored frames.

Parameters:
H_ACTIVE, 320, bytes per line with href high (160 px RGB565)
H_BLANK, 16, cycles per line with href low
V_ACTIVE, 120, active lines per frame
VSYNC_LINES, 3, line periods with vsync high
V_BACK, 2, blank line periods between vsync fall and first active line
V_FRONT, 2, blank line periods after last active line
BASE_ADDR, 16'h0000, framebuffer address of byte 0 of the frame

Ports:
pclk_24  in  1  24 MHz pixel clock; all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
start    in  1  sampled high in IDLE: transmit one frame
din      in  8  framebuffer read data, valid the cycle after addr is sampled by the RAM
addr     out 16 framebuffer read address
vsync    out 1  vertical sync, active high
href     out 1  horizontal reference, high while d carries valid bytes
d        out 8  pixel byte stream
busy     out 1  high while a frame is in progress
done     out 1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, reset_n=0): addr=BASE_ADDR, vsync=0, href=0, d=0, busy=0, done=0, state IDLE. Reset mid-frame aborts immediately. No partial-line completion.
- LINE_LEN = H_ACTIVE+H_BLANK. Frame = (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)*LINE_LEN output cycles.
- Timing-generator FSM: IDLE -> VSYNC -> VBACK -> ACTIVE -> VFRONT -> IDLE. ACTIVE has sub-phases: H_ACTIVE read cycles, then H_BLANK idle cycles per line. Counters: hcnt 0..LINE_LEN-1, vcnt line-within-phase.
- Read pipeline latency is 2 cycles: addr for byte k is driven in cycle t, and d = mem[addr] with href=1 in cycle t+2. vsync and href are generated on the addr timeline and delayed by 2 registers. Output timing is therefore exact and gap-free.
- start is sampled at edge E in IDLE. busy=1 from edge E. vsync is first high after edge E+2 and stays high for VSYNC_LINES*LINE_LEN cycles.
- Addresses: byte k of active line l reads BASE_ADDR + l*H_ACTIVE + k. Addresses increment contiguously and wrap modulo 2^16. Outside read cycles, addr holds its last value. It returns to BASE_ADDR when the frame ends.
- d=0 whenever href=0. vsync and href are never high together.
- done pulses high for one cycle, in the cycle immediately after the last V_FRONT output cycle. busy falls on that same edge. State returns to IDLE.
- start while busy is ignored. start high in the same cycle done is high is ignored, because the FSM is not yet in IDLE. start held high continuously produces back-to-back frames with exactly one idle cycle between them.
- Parameters with a value of 0 are legal for H_BLANK, V_BACK and V_FRONT (the phase is skipped). H_ACTIVE, V_ACTIVE and VSYNC_LINES must be at least 1.

Decomposition:
- Shared include ov7670_params.vh holds:
  - default geometry constants (QQVGA RGB565 widths),
  - state encodings for IDLE/VSYNC/VBACK/ACTIVE/VFRONT,
  - pipeline latency constant RD_LAT=2.
- One sub-module, ov7670_timing_gen, contains the hcnt/vcnt counters and the phase FSM. It outputs vsync_pre, href_pre, rd_en, frame_end.
- The top level holds the address counter, the 2-stage delay, and the d register.

Test Plan:
Tiny geometry for all scenarios unless noted: H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, BASE_ADDR=0; framebuffer preloaded with mem[i]=i+8'h10.
1. Single start pulse -> vsync high 6 cycles starting edge E+2; href pulses 4 cycles high / 2 low, 3 times; d = 10,11,12,13 / 14..17 / 18..1B; done single pulse 36 cycles after vsync rise; busy low afterward.
2. Loopback into ov7670_capture at default geometry -> captured addr/dout reproduce all 38400 framebuffer bytes in order.
3. start pulsed at the 10th busy cycle and again coincident with done -> no second frame; busy stays low.
4. start held high for 3 frames -> three identical frames; exactly 1 idle cycle between done and the next busy rise.
5. reset_n low during the second active line -> all outputs 0 asynchronously. A new start afterward reads from address 0 again, d=10 first.
6. BASE_ADDR=16'hFFFE -> addr sequence FFFE, FFFF, 0000, 0001 on line 0; d matches mem at the wrapped addresses.
